// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage PC / fetch controller.
package pc_fetch_ctrl_pkg;

  localparam int N_INST_ADDR = 32;
  localparam int PC_INC      = 4;

  typedef enum logic [1:0] {S_OFF, S_FETCH, S_WAIT} fetch_state_e;

  typedef enum logic [1:0] {SRC_NONE, SRC_FLUSH, SRC_BRANCH} redir_src_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: stall/redirect inputs, memory handshake and PC outputs.
// PC_ALIGN_CHECK_EN adds the o_addr_err pulse.
interface pc_fetch_ctrl_if import pc_fetch_ctrl_pkg::*; #(
  parameter int ADDR_W = N_INST_ADDR
);
  logic              i_stall;
  logic              i_flush;
  logic [ADDR_W-1:0] i_flush_pc;
  logic              i_branch_flag;
  logic [ADDR_W-1:0] i_branch_pc;
  logic              i_mem_ack;
  logic [ADDR_W-1:0] o_pc;
  logic              o_ce;
  logic              o_req;
  logic              o_kill;
  logic              o_redir_pend;
`ifdef PC_ALIGN_CHECK_EN
  logic              o_addr_err;
`endif

  modport master (
    input  i_stall, i_flush, i_flush_pc, i_branch_flag, i_branch_pc, i_mem_ack,
`ifdef PC_ALIGN_CHECK_EN
    output o_addr_err,
`endif
    output o_pc, o_ce, o_req, o_kill, o_redir_pend
  );

  modport slave (
    output i_stall, i_flush, i_flush_pc, i_branch_flag, i_branch_pc, i_mem_ack,
`ifdef PC_ALIGN_CHECK_EN
    input  o_addr_err,
`endif
    input  o_pc, o_ce, o_req, o_kill, o_redir_pend
  );
endinterface

// File: rtl/pc_fetch_ctrl_redir_buf.sv
// One-entry redirect buffer used while a fetch is outstanding.
// A flush always overwrites; a branch never overwrites a buffered flush.
module redir_buf import pc_fetch_ctrl_pkg::*; #(
  parameter int ADDR_W = N_INST_ADDR
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              set_flush,
  input  logic              set_branch,
  input  logic              clr,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic [ADDR_W-1:0] branch_pc,
  output logic              pend,
  output logic [ADDR_W-1:0] tgt
);
  redir_src_e src;

  // capture / overwrite / clear the buffered redirect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src <= SRC_NONE;
      tgt <= '0;
    end else if (clr) begin
      src <= SRC_NONE;
    end else if (set_flush) begin
      src <= SRC_FLUSH;
      tgt <= flush_pc;
    end else if (set_branch && src != SRC_FLUSH) begin
      src <= SRC_BRANCH;
      tgt <= branch_pc;
    end
  end

  assign pend = (src != SRC_NONE);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter sequencer and instruction-fetch handshake.
// Next PC priority: flush > buffered redirect > branch > PC+4 (wraps).
// Optional macro PC_ALIGN_CHECK_EN: misaligned targets are refused, o_addr_err
// pulses and the PC holds until a flush. Without it, target bits[1:0] are cleared.
module pc_fetch_ctrl import pc_fetch_ctrl_pkg::*; #(
  parameter int              ADDR_W   = N_INST_ADDR,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  pc_fetch_ctrl_if.master  io
);
  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              pend;
  logic [ADDR_W-1:0] pend_tgt;

  logic              take_redir, seq_adv, kill;
  logic              to_wait, to_fetch;
  logic              buf_flush, buf_branch, buf_clr;
  logic [ADDR_W-1:0] redir_tgt, load_pc;
  logic              pc_load, pc_inc;

  // Per-cycle decision: which redirect (if any) lands, whether the returning
  // instruction is stale, and how the outstanding fetch progresses.
  // A request in S_FETCH that is not acked the same cycle it is redirected is
  // simply dropped: nothing is outstanding yet, so no kill is needed.
  always_comb begin
    take_redir = 1'b0;
    redir_tgt  = io.i_flush_pc;
    seq_adv    = 1'b0;
    kill       = 1'b0;
    to_wait    = 1'b0;
    to_fetch   = 1'b0;
    buf_flush  = 1'b0;
    buf_branch = 1'b0;
    buf_clr    = 1'b0;
    case (state)
      S_OFF: take_redir = io.i_flush;
      S_FETCH: begin
        if (io.i_flush) begin
          take_redir = 1'b1;
          kill       = io.i_mem_ack;
        end else if (!io.i_stall) begin
          if (io.i_branch_flag) begin
            take_redir = 1'b1;
            redir_tgt  = io.i_branch_pc;
            kill       = io.i_mem_ack;
          end else if (io.i_mem_ack) begin
            seq_adv = 1'b1;
          end else begin
            to_wait = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (io.i_mem_ack) begin
          to_fetch = 1'b1;
          buf_clr  = 1'b1;
          kill     = pend | io.i_flush | io.i_branch_flag;
          // a buffered redirect is applied even under stall so the buffer
          // never outlives the fetch it was waiting on
          if (io.i_flush) begin
            take_redir = 1'b1;
          end else if (pend) begin
            take_redir = 1'b1;
            redir_tgt  = pend_tgt;
          end else if (!io.i_stall) begin
            if (io.i_branch_flag) begin
              take_redir = 1'b1;
              redir_tgt  = io.i_branch_pc;
            end else begin
              seq_adv = 1'b1;
            end
          end
        end else if (io.i_flush) begin
          // flush moves the PC now and marks the outstanding fetch stale
          take_redir = 1'b1;
          buf_flush  = 1'b1;
        end else if (io.i_branch_flag) begin
          buf_branch = 1'b1;
        end
      end
      default: ;
    endcase
  end

  redir_buf #(.ADDR_W(ADDR_W)) u_redir_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .set_flush (buf_flush),
    .set_branch(buf_branch),
    .clr       (buf_clr),
    .flush_pc  (io.i_flush_pc),
    .branch_pc (io.i_branch_pc),
    .pend      (pend),
    .tgt       (pend_tgt)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic halted, addr_err, tgt_bad;

  assign tgt_bad = take_redir && (redir_tgt[1:0] != 2'b00);
  assign load_pc = redir_tgt;
  assign pc_load = take_redir && !tgt_bad && (!halted || io.i_flush);
  assign pc_inc  = seq_adv && !halted;

  // one-cycle error pulse; PC frozen until a good flush target arrives
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      halted   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= tgt_bad;
      if (tgt_bad)                     halted <= 1'b1;
      else if (pc_load && io.i_flush)  halted <= 1'b0;
    end
  end

  assign io.o_addr_err = addr_err;
`else
  assign load_pc = redir_tgt & ~ADDR_W'(3);
  assign pc_load = take_redir;
  assign pc_inc  = seq_adv;
`endif

  // fetch FSM with registered PC and chip enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_OFF;
      pc    <= RESET_PC;
      ce    <= 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          state <= S_FETCH;
          ce    <= 1'b1;
        end
        S_FETCH: if (to_wait)  state <= S_WAIT;
        S_WAIT:  if (to_fetch) state <= S_FETCH;
        default: state <= S_OFF;
      endcase
      if (pc_load)     pc <= load_pc;
      else if (pc_inc) pc <= pc + ADDR_W'(PC_INC);
    end
  end

  assign io.o_pc         = pc;
  assign io.o_ce         = ce;
  assign io.o_req        = (state == S_WAIT) || (state == S_FETCH && !io.i_stall);
  assign io.o_kill       = kill;
  assign io.o_redir_pend = pend;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_fetch_ctrl_if #(.ADDR_W(32)) io();

  pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io     (io.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state
  typedef struct { bit is_flush; logic [31:0] tgt; } pend_t;
  bit          m_on;        // controller has left the dead cycle after reset
  bit          m_out;       // a fetch is outstanding
  logic [31:0] m_pc;
  pend_t       pend_q[$];   // at most one buffered redirect

  // current inputs and expected outputs for this cycle
  bit          c_st, c_fl, c_br, c_ack;
  logic [31:0] c_fpc, c_bpc;
  logic        exp_req, exp_kill;

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic model_reset();
    m_on = 0; m_out = 0; m_pc = 32'h0; pend_q.delete();
  endtask

  // drive inputs for this cycle and derive the expected combinational outputs
  task automatic apply(input bit st, input bit fl, input logic [31:0] fpc,
                       input bit br, input logic [31:0] bpc, input bit ack);
    c_st = st; c_fl = fl; c_fpc = fpc; c_br = br; c_bpc = bpc; c_ack = ack;
    io.i_stall = st; io.i_flush = fl; io.i_flush_pc = fpc;
    io.i_branch_flag = br; io.i_branch_pc = bpc; io.i_mem_ack = ack;
    #1;
    exp_req  = m_on && (m_out || !st);
    exp_kill = 1'b0;
    if (m_on && ack) begin
      if (!m_out) exp_kill = fl || (!st && br);
      else        exp_kill = (pend_q.size() != 0) || fl || br;
    end
  endtask

  // advance the model by the spec rules, then the clock
  task automatic tick();
    pend_t p;
    if (!m_on) begin
      m_on = 1;
      if (c_fl) m_pc = al(c_fpc);
    end else if (!m_out) begin
      if (c_fl) m_pc = al(c_fpc);
      else if (!c_st) begin
        if (c_br)       m_pc = al(c_bpc);
        else if (c_ack) m_pc = m_pc + 32'd4;
        else            m_out = 1;
      end
    end else if (c_ack) begin
      m_out = 0;
      if (c_fl)                    m_pc = al(c_fpc);
      else if (pend_q.size() != 0) m_pc = al(pend_q[0].tgt);
      else if (!c_st)              m_pc = c_br ? al(c_bpc) : m_pc + 32'd4;
      pend_q.delete();
    end else if (c_fl) begin
      m_pc = al(c_fpc);
      p.is_flush = 1; p.tgt = c_fpc;
      pend_q.delete(); pend_q.push_back(p);
    end else if (c_br && !(pend_q.size() != 0 && pend_q[0].is_flush)) begin
      p.is_flush = 0; p.tgt = c_bpc;
      pend_q.delete(); pend_q.push_back(p);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (io.o_pc !== 32'h0) begin n_errors++; $display("FAIL rst_pc: got %h want 0", io.o_pc); end
    n_checks++; if (io.o_ce !== 1'b0) begin n_errors++; $display("FAIL rst_ce: got %b want 0", io.o_ce); end
    n_checks++; if (io.o_req !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b want 0", io.o_req); end
    n_checks++; if (io.o_kill !== 1'b0) begin n_errors++; $display("FAIL rst_kill: got %b want 0", io.o_kill); end
    n_checks++; if (io.o_redir_pend !== 1'b0) begin n_errors++; $display("FAIL rst_pend: got %b want 0", io.o_redir_pend); end
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 1);
    n_checks++; if (io.o_ce !== 1'b0) begin n_errors++; $display("FAIL dead_ce: got %b want 0", io.o_ce); end
    n_checks++; if (io.o_req !== 1'b0) begin n_errors++; $display("FAIL dead_req: got %b want 0", io.o_req); end
    tick();
  endtask

  task automatic test_seq_fetch();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 0, 1);
      n_checks++; if (io.o_pc !== 32'(i * 4)) begin n_errors++; $display("FAIL seq_pc%0d: got %h want %h", i, io.o_pc, 32'(i * 4)); end
      n_checks++; if (io.o_ce !== 1'b1 || io.o_req !== 1'b1) begin n_errors++; $display("FAIL seq_ce_req%0d: got %b%b want 11", i, io.o_ce, io.o_req); end
      n_checks++; if (io.o_kill !== 1'b0) begin n_errors++; $display("FAIL seq_kill%0d: got %b want 0", i, io.o_kill); end
      tick();
    end
  endtask

  task automatic test_wait_ack();
    apply(0, 1, 32'h8, 0, 0, 0);
    n_checks++; if (io.o_kill !== 1'b0) begin n_errors++; $display("FAIL wait_redir_kill: got %b want 0", io.o_kill); end
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0);
      n_checks++; if (io.o_pc !== 32'h8 || io.o_req !== 1'b1) begin n_errors++; $display("FAIL wait_hold%0d: got pc %h req %b want 8/1", i, io.o_pc, io.o_req); end
      tick();
    end
    apply(0, 0, 0, 0, 0, 1);
    tick();
    n_checks++; if (io.o_pc !== 32'hC) begin n_errors++; $display("FAIL wait_adv: got %h want c", io.o_pc); end
  endtask

  task automatic test_branch_pending();
    apply(0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 1, 32'h100, 0); tick();
    apply(0, 0, 0, 0, 0, 0);
    n_checks++; if (io.o_redir_pend !== 1'b1 || io.o_pc !== 32'hC) begin n_errors++; $display("FAIL bp_pend: got pend %b pc %h want 1/c", io.o_redir_pend, io.o_pc); end
    tick();
    apply(0, 0, 0, 0, 0, 1);
    n_checks++; if (io.o_kill !== 1'b1) begin n_errors++; $display("FAIL bp_kill: got %b want 1", io.o_kill); end
    tick();
    n_checks++; if (io.o_pc !== 32'h100 || io.o_redir_pend !== 1'b0) begin n_errors++; $display("FAIL bp_load: got pc %h pend %b want 100/0", io.o_pc, io.o_redir_pend); end
  endtask

  task automatic test_flush_branch_same();
    apply(0, 1, 32'h180, 1, 32'h100, 1);
    n_checks++; if (io.o_kill !== 1'b1) begin n_errors++; $display("FAIL fb_kill: got %b want 1", io.o_kill); end
    tick();
    n_checks++; if (io.o_pc !== 32'h180) begin n_errors++; $display("FAIL fb_pc: got %h want 180", io.o_pc); end
  endtask

  task automatic test_flush_over_pending();
    apply(0, 0, 0, 0, 0, 1); tick();          // pc 0x184
    apply(0, 0, 0, 0, 0, 0); tick();          // outstanding
    apply(0, 0, 0, 1, 32'h100, 0); tick();    // branch buffered
    apply(0, 1, 32'h180, 0, 0, 0); tick();    // flush overwrites
    n_checks++; if (io.o_pc !== 32'h180 || io.o_redir_pend !== 1'b1) begin n_errors++; $display("FAIL fop_flush: got pc %h pend %b want 180/1", io.o_pc, io.o_redir_pend); end
    apply(0, 0, 0, 1, 32'h300, 0); tick();    // must not displace the flush
    apply(0, 0, 0, 0, 0, 1);
    n_checks++; if (io.o_kill !== 1'b1) begin n_errors++; $display("FAIL fop_kill: got %b want 1", io.o_kill); end
    tick();
    n_checks++; if (io.o_pc !== 32'h180 || io.o_redir_pend !== 1'b0) begin n_errors++; $display("FAIL fop_pc: got pc %h pend %b want 180/0", io.o_pc, io.o_redir_pend); end
  endtask

  task automatic test_stall();
    apply(0, 1, 32'h20, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 0, 0, 1);
      n_checks++; if (io.o_pc !== 32'h20 || io.o_req !== 1'b0 || io.o_kill !== 1'b0) begin n_errors++; $display("FAIL stall%0d: got pc %h req %b kill %b want 20/0/0", i, io.o_pc, io.o_req, io.o_kill); end
      tick();
    end
    apply(0, 0, 0, 0, 0, 1); tick();
    n_checks++; if (io.o_pc !== 32'h24) begin n_errors++; $display("FAIL stall_rel: got %h want 24", io.o_pc); end
  endtask

  task automatic test_wrap();
    apply(0, 1, 32'hFFFF_FFFC, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 1); tick();
    n_checks++; if (io.o_pc !== 32'h0) begin n_errors++; $display("FAIL wrap: got %h want 0", io.o_pc); end
  endtask

  task automatic test_align();
    apply(0, 1, 32'h103, 0, 0, 0); tick();
    n_checks++; if (io.o_pc !== 32'h100) begin n_errors++; $display("FAIL align_flush: got %h want 100", io.o_pc); end
    apply(0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 1, 32'h206, 0); tick();
    apply(0, 0, 0, 0, 0, 1); tick();
    n_checks++; if (io.o_pc !== 32'h204) begin n_errors++; $display("FAIL align_branch: got %h want 204", io.o_pc); end
  endtask

  task automatic test_reset_mid_wait();
    apply(0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 1, 32'h40, 0); tick();
    n_checks++; if (io.o_redir_pend !== 1'b1) begin n_errors++; $display("FAIL rmw_pre: got %b want 1", io.o_redir_pend); end
    apply(0, 0, 0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (io.o_pc !== 32'h0 || io.o_ce !== 1'b0 || io.o_req !== 1'b0) begin n_errors++; $display("FAIL rmw_async: got pc %h ce %b req %b want 0/0/0", io.o_pc, io.o_ce, io.o_req); end
    n_checks++; if (io.o_kill !== 1'b0 || io.o_redir_pend !== 1'b0) begin n_errors++; $display("FAIL rmw_kill_pend: got %b%b want 00", io.o_kill, io.o_redir_pend); end
    model_reset();
    @(posedge clk); @(negedge clk);
    n_checks++; if (io.o_pc !== 32'h0) begin n_errors++; $display("FAIL rmw_ack_ignored: got %h want 0", io.o_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] fpc, bpc;
    for (int i = 0; i < 400; i++) begin
      fpc = $urandom; bpc = $urandom;
      if ($urandom_range(3) != 0) fpc[1:0] = 2'b00;
      if ($urandom_range(3) != 0) bpc[1:0] = 2'b00;
      apply($urandom_range(9) < 2, $urandom_range(24) < 2, fpc,
            $urandom_range(19) < 3, bpc, $urandom_range(9) < 5);
      n_checks++; if (io.o_pc !== m_pc) begin n_errors++; $display("FAIL rnd_pc@%0d: got %h want %h", i, io.o_pc, m_pc); end
      n_checks++; if (io.o_ce !== m_on) begin n_errors++; $display("FAIL rnd_ce@%0d: got %b want %b", i, io.o_ce, m_on); end
      n_checks++; if (io.o_req !== exp_req) begin n_errors++; $display("FAIL rnd_req@%0d: got %b want %b", i, io.o_req, exp_req); end
      n_checks++; if (io.o_kill !== exp_kill) begin n_errors++; $display("FAIL rnd_kill@%0d: got %b want %b", i, io.o_kill, exp_kill); end
      n_checks++; if (io.o_redir_pend !== (pend_q.size() != 0)) begin n_errors++; $display("FAIL rnd_pend@%0d: got %b want %b", i, io.o_redir_pend, pend_q.size() != 0); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    io.i_stall = 0; io.i_flush = 0; io.i_flush_pc = '0;
    io.i_branch_flag = 0; io.i_branch_pc = '0; io.i_mem_ack = 0;
    model_reset();
    test_reset();
    test_seq_fetch();
    test_wait_ack();
    test_branch_pending();
    test_flush_branch_same();
    test_flush_over_pending();
    test_stall();
    test_wrap();
    test_align();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
